// File: rtl/led_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
//
// Purpose : Shared types and helpers for the LED mode sequencer.
//           - mode_t     : display mode encoding (also the mode_out encoding)
//           - cnt_width  : width of the shared counter type, sized for the
//                          larger of the tick divider and the debounce length
//           - next_mode  : OFF -> WALK -> COUNT -> BLINK -> OFF
// Ports   : none (package)
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    // Counter width for values 0..max(a,b)-1. Never narrower than one bit so
    // a degenerate DEBOUNCE_CYCLES=1 build still has a legal counter.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_OFF:   n = MODE_WALK;
            MODE_WALK:  n = MODE_COUNT;
            MODE_COUNT: n = MODE_BLINK;
            default:    n = MODE_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_if.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer_if
//
// Purpose : Bundles the board-side signals of the LED mode sequencer.
// Signals :
//   button    raw asynchronous push-button, active high   (board -> sequencer)
//   enable    synchronous run enable, low freezes pattern  (board -> sequencer)
//   mode_out  current display mode                         (sequencer -> board)
//   leds      LED drive, active high, NUM_LEDS wide        (sequencer -> board)
//   tick_out  one-cycle pulse per pattern tick             (sequencer -> board)
// Modports:
//   master    board / environment side (drives button, enable)
//   slave     sequencer side (drives mode_out, leds, tick_out)
// -----------------------------------------------------------------------------
interface led_mode_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 4
);

    logic                button;
    logic                enable;
    mode_t               mode_out;
    logic [NUM_LEDS-1:0] leds;
    logic                tick_out;

    modport master (
        output button,
        output enable,
        input  mode_out,
        input  leds,
        input  tick_out
    );

    modport slave (
        input  button,
        input  enable,
        output mode_out,
        output leds,
        output tick_out
    );

endinterface

// File: rtl/led_mode_sequencer_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Purpose : Turns a raw asynchronous push-button into a single-cycle press
//           pulse. Two-flop synchroniser, then a debounce counter that only
//           accepts a new level after DEBOUNCE_CYCLES consecutive differing
//           synchronised samples, then a rising-edge detector on the
//           debounced level. Releases never produce a pulse.
// Ports   :
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   button   in   raw push-button, active high, asynchronous to clock
//   press    out  one-cycle registered pulse per accepted press
// Timing  : a clean step on button is accepted on the edge DEBOUNCE_CYCLES+2
//           (first sampling edge = 1) and press is high after edge
//           DEBOUNCE_CYCLES+3.
// -----------------------------------------------------------------------------
module button_debounce
    import led_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 6_000_000,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, 2)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic press
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             deb_state;
    logic             deb_prev;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            deb_state <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            sync_1 <= button;
            sync_2 <= sync_1;

            // Any sample that agrees with the accepted level restarts the
            // count, so only an unbroken run of differing samples flips it.
            if (sync_2 == deb_state) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_state <= sync_2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end

            deb_prev <= deb_state;
            press    <= deb_state & ~deb_prev;
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//
// Purpose : Cycles the board status LEDs through display modes chosen by a
//           push-button. A divider derives the slow pattern tick from the
//           system clock; each tick advances the LED pattern according to
//           the current mode. A debounced button press steps the mode
//           OFF -> WALK -> COUNT -> BLINK -> OFF and reloads the pattern.
// Ports   :
//   clock    in   system clock, single domain
//   reset_n  in   asynchronous active-low reset; the board releases it
//                 synchronously to clock
//   io       slave modport of led_mode_sequencer_if:
//              button   in   raw push-button, active high
//              enable   in   run enable; low holds the pattern and the divider
//              mode_out out  current mode (0 OFF, 1 WALK, 2 COUNT, 3 BLINK)
//              leds     out  LED drive, NUM_LEDS wide, active high
//              tick_out out  one-cycle pulse per pattern tick
// Notes   : every output is a flop; nothing combinational reaches the pins.
// -----------------------------------------------------------------------------
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 6_000_000,
    parameter int NUM_LEDS        = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    led_mode_sequencer_if.slave  io
);

    localparam int               CNT_W     = cnt_width(TICK_DIV, DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    mode_t               mode;
    mode_t               mode_nxt;
    logic [NUM_LEDS-1:0] leds;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic                tick_hit;
    logic                press;

    // Pattern loaded on entry to a mode; only WALK starts non-zero.
    function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_t m);
        logic [NUM_LEDS-1:0] p;
        p = '0;
        if (m == MODE_WALK) begin
            p = NUM_LEDS'(1);
        end
        return p;
    endfunction

    // One tick's worth of pattern movement for the current mode.
    function automatic logic [NUM_LEDS-1:0] step_pattern(input mode_t               m,
                                                         input logic [NUM_LEDS-1:0] p);
        logic [NUM_LEDS-1:0] n;
        case (m)
            MODE_WALK:  n = {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
            MODE_COUNT: n = p + NUM_LEDS'(1);
            MODE_BLINK: n = ~p;
            default:    n = '0;
        endcase
        return n;
    endfunction

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .button  (io.button),
        .press   (press)
    );

    assign mode_nxt = next_mode(mode);

    // The divider only reaches its last value while running, so a frozen
    // divider can never raise a tick.
    assign tick_hit = io.enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode     <= MODE_OFF;
            leds     <= '0;
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            // tick_out reports the divider wrap even when a press
            // pre-empts the LED update on the same edge.
            tick <= tick_hit;

            if (press) begin
                // A press outranks the tick and restarts the tick period
                // so the new mode always gets a full first step.
                mode     <= mode_nxt;
                leds     <= init_pattern(mode_nxt);
                tick_cnt <= '0;
            end else if (io.enable) begin
                if (tick_hit) begin
                    tick_cnt <= '0;
                    leds     <= step_pattern(mode, leds);
                end else begin
                    tick_cnt <= tick_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign io.mode_out = mode;
    assign io.leds     = leds;
    assign io.tick_out = tick;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_mode_sequencer
//
// Directed stimulus with a scoreboard. The stimulus process queues the
// expected {mode_out, leds, tick_out} for specific cycles (counted as clock
// edges since the last reset release); a monitor process samples the DUT on
// each falling edge and compares against the entry due in that cycle.
// Parameters: TICK_DIV=4, DEBOUNCE_CYCLES=3, NUM_LEDS=4.
// -----------------------------------------------------------------------------
module tb_led_mode_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int NL       = 4;

    typedef struct {
        int    cyc;
        int    mode;
        int    leds;
        int    tick;
        string name;
    } exp_t;

    logic  clock   = 1'b0;
    logic  reset_n = 1'b0;
    int    cyc     = 0;
    int    checks  = 0;
    int    errors  = 0;
    exp_t  q[$];
    exp_t  mon_e;

    led_mode_sequencer_if #(.NUM_LEDS(NL)) io();

    led_mode_sequencer #(
        .TICK_DIV        (TICK_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .NUM_LEDS        (NL)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io.slave)
    );

    always #5 clock = ~clock;

    // Edge counter: edge 1 is the first rising edge after reset release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc = 0;
        else          cyc = cyc + 1;
    end

    // Monitor: compare whatever is due in this cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e  = q.pop_front();
                checks = checks + 1;
                if (mon_e.cyc != cyc ||
                    io.mode_out !== 2'(mon_e.mode) ||
                    io.leds     !== 4'(mon_e.leds) ||
                    io.tick_out !== 1'(mon_e.tick)) begin
                    errors = errors + 1;
                    $display("FAIL %s @cyc %0d (due %0d): mode/leds/tick got %0d/%b/%b expected %0d/%b/%b",
                             mon_e.name, cyc, mon_e.cyc, io.mode_out, io.leds, io.tick_out,
                             mon_e.mode, 4'(mon_e.leds), 1'(mon_e.tick));
                end
            end
        end
    end

    function automatic void expect_at(input int c, input int m, input int l, input int t,
                                      input string nm);
        exp_t e;
        e.cyc  = c;
        e.mode = m;
        e.leds = l;
        e.tick = t;
        e.name = nm;
        q.push_back(e);
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic do_reset(input logic btn);
        @(negedge clock);
        reset_n   = 1'b0;
        io.button = btn;
        io.enable = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic drain(input int last, input string nm);
        wait_to(last + 1);
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s_drain: %0d expectations left, required 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic check_now(input string nm, input int m, input int l, input int t);
        checks = checks + 1;
        if (io.mode_out !== 2'(m) || io.leds !== 4'(l) || io.tick_out !== 1'(t)) begin
            errors = errors + 1;
            $display("FAIL %s: mode/leds/tick got %0d/%b/%b expected %0d/%b/%b",
                     nm, io.mode_out, io.leds, io.tick_out, m, 4'(l), 1'(t));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        io.button = 1'b0;
        io.enable = 1'b1;

        // A: button held from edge 1 -> WALK on edge 7, then walking bit.
        do_reset(1'b1);
        expect_at(1,  0, 0, 0, "A_reset");
        expect_at(4,  0, 0, 1, "A_tick_off");
        expect_at(6,  0, 0, 0, "A_before_mode");
        expect_at(7,  1, 1, 0, "A_walk_entry");
        expect_at(10, 1, 1, 0, "A_walk_hold");
        expect_at(11, 1, 2, 1, "A_walk_0010");
        expect_at(12, 1, 2, 0, "A_tick_one_cycle");
        expect_at(15, 1, 4, 1, "A_walk_0100");
        expect_at(19, 1, 8, 1, "A_walk_1000");
        expect_at(23, 1, 1, 1, "A_walk_wrap");
        expect_at(30, 1, 2, 0, "A_release_no_press");
        expect_at(31, 1, 4, 1, "A_walk_after_release");
        wait_to(24);
        io.button = 1'b0;
        drain(31, "A");

        // B: idle, glitch, then presses through COUNT and BLINK back to OFF.
        do_reset(1'b0);
        expect_at(1,   0, 0,  0, "B_reset");
        expect_at(3,   0, 0,  0, "B_no_tick_yet");
        expect_at(4,   0, 0,  1, "B_first_tick");
        expect_at(5,   0, 0,  0, "B_tick_low");
        expect_at(8,   0, 0,  1, "B_second_tick");
        expect_at(10,  0, 0,  0, "B_glitch_ignored");
        expect_at(12,  0, 0,  1, "B_third_tick");
        expect_at(18,  0, 0,  0, "B_before_press1");
        expect_at(19,  1, 1,  0, "B_walk");
        expect_at(23,  1, 2,  1, "B_walk_0010");
        expect_at(35,  1, 1,  1, "B_walk_wrap");
        expect_at(39,  1, 2,  1, "B_walk_again");
        expect_at(40,  2, 0,  0, "B_count_entry");
        expect_at(44,  2, 1,  1, "B_count_1");
        expect_at(48,  2, 2,  1, "B_count_2");
        expect_at(100, 2, 15, 1, "B_count_15");
        expect_at(104, 2, 0,  1, "B_count_wrap");
        expect_at(108, 2, 1,  1, "B_count_after_wrap");
        expect_at(112, 2, 2,  1, "B_count_before_blink");
        expect_at(113, 3, 0,  0, "B_blink_entry");
        expect_at(117, 3, 15, 1, "B_blink_on");
        expect_at(121, 3, 0,  1, "B_blink_off");
        expect_at(125, 3, 15, 1, "B_blink_on2");
        expect_at(133, 3, 15, 1, "B_blink_on3");
        expect_at(134, 0, 0,  0, "B_back_to_off");
        expect_at(138, 0, 0,  1, "B_off_tick");
        wait_to(2);   io.button = 1'b1;
        wait_to(4);   io.button = 1'b0;
        wait_to(12);  io.button = 1'b1;
        wait_to(22);  io.button = 1'b0;
        wait_to(33);  io.button = 1'b1;
        wait_to(43);  io.button = 1'b0;
        wait_to(106); io.button = 1'b1;
        wait_to(116); io.button = 1'b0;
        wait_to(127); io.button = 1'b1;
        wait_to(137); io.button = 1'b0;
        drain(138, "B");

        // C: enable low for 20 cycles in WALK at 0100.
        do_reset(1'b1);
        expect_at(7,  1, 1, 0, "C_walk_entry");
        expect_at(11, 1, 2, 1, "C_walk_0010");
        expect_at(15, 1, 4, 1, "C_walk_0100");
        expect_at(16, 1, 4, 0, "C_before_freeze");
        expect_at(20, 1, 4, 0, "C_frozen_no_tick1");
        expect_at(23, 1, 4, 0, "C_frozen_no_tick2");
        expect_at(27, 1, 4, 0, "C_frozen_no_tick3");
        expect_at(36, 1, 4, 0, "C_frozen_end");
        expect_at(38, 1, 4, 0, "C_resumed_counting");
        expect_at(39, 1, 8, 1, "C_tick_from_held_count");
        expect_at(40, 1, 8, 0, "C_after_resume_tick");
        wait_to(8);  io.button = 1'b0;
        wait_to(16); io.enable = 1'b0;
        wait_to(36); io.enable = 1'b1;
        drain(40, "C");

        // D: press pulse lands on the same edge as a WALK tick.
        do_reset(1'b1);
        expect_at(19, 1, 8, 1, "D_walk_1000");
        expect_at(22, 1, 8, 0, "D_before_collision");
        expect_at(23, 2, 0, 1, "D_press_beats_tick");
        expect_at(24, 2, 0, 0, "D_after_collision");
        expect_at(27, 2, 1, 1, "D_count_first_tick");
        wait_to(8);  io.button = 1'b0;
        wait_to(16); io.button = 1'b1;
        wait_to(26); io.button = 1'b0;
        drain(27, "D");

        // E: asynchronous reset between clock edges while in BLINK.
        do_reset(1'b1);
        expect_at(23, 2, 0,  1, "E_count_entry");
        expect_at(27, 2, 1,  1, "E_count_1");
        expect_at(35, 2, 3,  1, "E_count_3");
        expect_at(37, 3, 0,  0, "E_blink_entry");
        expect_at(41, 3, 15, 1, "E_blink_on");
        expect_at(45, 3, 0,  1, "E_blink_off");
        expect_at(49, 3, 15, 1, "E_blink_on2");
        wait_to(8);  io.button = 1'b0;
        wait_to(16); io.button = 1'b1;
        wait_to(26); io.button = 1'b0;
        wait_to(30); io.button = 1'b1;
        wait_to(40); io.button = 1'b0;
        wait_to(49);
        @(posedge clock);
        #2;
        check_now("E_blink_before_reset", 3, 15, 0);
        reset_n = 1'b0;
        #1;
        check_now("E_async_reset_clears", 0, 0, 0);
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL E_drain: %0d expectations left, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        expect_at(1, 0, 0, 0, "E_after_release");
        expect_at(4, 0, 0, 1, "E_first_tick_after_release");
        drain(4, "E2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
